// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: round-robin output-port arbiter with packet lock.
// Optional XFER idle timeout: define CROSSBAR_ARB_TIMEOUT_EN.
module crossbar_arbiter #(
  parameter int          P_SRC_NUM = 4,
  parameter logic [15:0] P_TIMEOUT = 16'd1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [P_SRC_NUM-1:0]   i_trans_req,
  output logic [P_SRC_NUM-1:0]   o_trans_grant,
  input  logic [P_SRC_NUM-1:0]   s_axis_rx_tvalid,
  input  logic [64*P_SRC_NUM-1:0] s_axis_rx_tdata,
  input  logic [P_SRC_NUM-1:0]   s_axis_rx_tlast,
  input  logic [8*P_SRC_NUM-1:0] s_axis_rx_tkeep,
  input  logic [P_SRC_NUM-1:0]   s_axis_rx_tuser,
  output logic [P_SRC_NUM-1:0]   s_axis_rx_tready,
  output logic                   m_axis_tx_tvalid,
  output logic [63:0]            m_axis_tx_tdata,
  output logic                   m_axis_tx_tlast,
  output logic [7:0]             m_axis_tx_tkeep,
  output logic                   m_axis_tx_tuser,
  input  logic                   m_axis_tx_tready,
  output logic                   o_busy,
  output logic [2:0]             o_cur_src,
  output logic                   o_timeout
);
  localparam int SEL_W = 3;

  if (P_SRC_NUM < 2 || P_SRC_NUM > 8 ||
      P_TIMEOUT < 16'd2) begin : g_bad_cfg
    $error("crossbar_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER
  } state_t;

  state_t           r_state;
  state_t           nx_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] nx_sel;
  logic             found;
  logic             acc;
  logic             tmo;

  // first requester strictly after the pointer, wrapping
  always_comb begin
    nx_sel = r_sel;
    found  = 1'b0;
    for (int i = 1; i <= P_SRC_NUM; i++) begin
      for (int j = 0; j < P_SRC_NUM; j++) begin
        if (!found && i_trans_req[j] &&
            j == (int'(r_rr_ptr) + i) % P_SRC_NUM) begin
          found  = 1'b1;
          nx_sel = SEL_W'(j);
        end
      end
    end
  end

  always_comb begin
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tdata  = '0;
    m_axis_tx_tlast  = 1'b0;
    m_axis_tx_tkeep  = 8'hff;
    m_axis_tx_tuser  = 1'b0;
    s_axis_rx_tready = '0;
    if (r_state == XFER) begin
      for (int i = 0; i < P_SRC_NUM; i++) begin
        if (r_sel == SEL_W'(i)) begin
          m_axis_tx_tvalid    = s_axis_rx_tvalid[i];
          m_axis_tx_tdata     = s_axis_rx_tdata[64*i +: 64];
          m_axis_tx_tlast     = s_axis_rx_tlast[i];
          m_axis_tx_tkeep     = s_axis_rx_tkeep[8*i +: 8];
          m_axis_tx_tuser     = s_axis_rx_tuser[i];
          s_axis_rx_tready[i] = m_axis_tx_tready;
        end
      end
    end
  end

  assign acc = m_axis_tx_tvalid && m_axis_tx_tready;

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == GRANT || acc) begin
      r_cnt <= '0;
    end else if (r_state == XFER) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign tmo = (r_state == XFER) && !acc &&
               (r_cnt == P_TIMEOUT - 16'd1);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nx_state      = r_state;
    o_trans_grant = '0;
    unique case (r_state)
      IDLE: begin
        if (|i_trans_req) nx_state = GRANT;
      end
      GRANT: begin
        for (int i = 0; i < P_SRC_NUM; i++) begin
          if (r_sel == SEL_W'(i)) o_trans_grant[i] = 1'b1;
        end
        nx_state = XFER;
      end
      XFER: begin
        if ((acc && m_axis_tx_tlast) || tmo) nx_state = IDLE;
      end
      default: nx_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_rr_ptr <= SEL_W'(P_SRC_NUM - 1);
    end else begin
      r_state <= nx_state;
      if (r_state == IDLE && |i_trans_req) begin
        r_sel    <= nx_sel;
        r_rr_ptr <= nx_sel;
      end
    end
  end

  assign o_busy    = (r_state != IDLE);
  assign o_cur_src = r_sel;
  assign o_timeout = tmo;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// tb_crossbar_arbiter: directed vector table plus multi-cycle sequences.
// Timeout sequence depends on CROSSBAR_ARB_TIMEOUT_EN.
module tb_crossbar_arbiter;
  localparam int N = 4;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic [N-1:0]   req, grant, rx_vld, rx_last, rx_user, rx_rdy;
  logic [64*N-1:0] rx_data;
  logic [8*N-1:0] rx_keep;
  logic           tx_vld, tx_last, tx_user, tx_rdy, busy, tmo;
  logic [63:0]    tx_data;
  logic [7:0]     tx_keep;
  logic [2:0]     cur;

  always #5 i_clk = ~i_clk;

  crossbar_arbiter #(.P_SRC_NUM(N), .P_TIMEOUT(16'd16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_trans_req(req), .o_trans_grant(grant),
    .s_axis_rx_tvalid(rx_vld), .s_axis_rx_tdata(rx_data),
    .s_axis_rx_tlast(rx_last), .s_axis_rx_tkeep(rx_keep),
    .s_axis_rx_tuser(rx_user), .s_axis_rx_tready(rx_rdy),
    .m_axis_tx_tvalid(tx_vld), .m_axis_tx_tdata(tx_data),
    .m_axis_tx_tlast(tx_last), .m_axis_tx_tkeep(tx_keep),
    .m_axis_tx_tuser(tx_user), .m_axis_tx_tready(tx_rdy),
    .o_busy(busy), .o_cur_src(cur), .o_timeout(tmo)
  );

  typedef struct {
    logic [3:0] req, vld, last, user;
    logic [7:0] keep, beat;
    logic       trdy;
    logic [3:0] grant;
    logic       busy, xfer;
    logic [2:0] src;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [63:0] pat(int s, logic [7:0] b);
    return {4'hD, 4'(s), 48'h0123_4567_89AB ^ {40'h0, b}, b};
  endfunction

  function automatic vec_t mk(
    input logic [3:0] rq, vl, ls, us,
    input logic [7:0] kp, bt,
    input logic tr,
    input logic [3:0] eg,
    input logic eb, ex,
    input logic [2:0] es);
    vec_t v;
    v.req = rq; v.vld = vl; v.last = ls; v.user = us;
    v.keep = kp; v.beat = bt; v.trdy = tr;
    v.grant = eg; v.busy = eb; v.xfer = ex; v.src = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rq, vl, ls, us,
                       input logic [7:0] kp, bt, input logic tr);
    req = rq; rx_vld = vl; rx_last = ls; rx_user = us; tx_rdy = tr;
    for (int s = 0; s < N; s++) begin
      rx_data[64*s +: 64] = pat(s, bt);
      rx_keep[8*s +: 8]   = kp;
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_grant"}, 64'(grant), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_tvalid"}, 64'(tx_vld), 64'd0);
    chk({nm, "_tdata"}, tx_data, 64'd0);
    chk({nm, "_tkeep"}, 64'(tx_keep), 64'hff);
    chk({nm, "_tready"}, 64'(rx_rdy), 64'd0);
    chk({nm, "_cur"}, 64'(cur), 64'd0);
  endtask

  initial begin
    int acc_cnt;
    int seen;
    vec_t v;

    // single source 2, 8 beats
    tbl.push_back(mk(4'b0100, 0, 0, 0, 8'hff, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 0, 8'hff, 0, 1, 4'b0100, 1, 0, 2));
    for (int b = 0; b < 8; b++) begin
      tbl.push_back(mk(4'b0000, 4'b0100, (b == 7) ? 4'b0100 : 4'b0000,
                       b[0] ? 4'b0100 : 4'b0000,
                       (b == 7) ? 8'h0f : 8'hff, 8'(b), 1,
                       4'b0000, 1, 1, 2));
    end
    // isolation: source 1 locked, source 3 busy on its own lane
    tbl.push_back(mk(4'b0010, 0, 0, 0, 8'hff, 0, 1, 4'b0000, 0, 0, 2));
    tbl.push_back(mk(4'b0010, 0, 0, 0, 8'hff, 0, 1, 4'b0010, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1010, 4'b0000, 4'b1000, 8'hff, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 8'hff, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 4'b1010, 4'b1010, 4'b0010, 8'h3c, 2, 1, 0, 1, 1, 1));
    // backpressure on source 0
    tbl.push_back(mk(4'b0001, 0, 0, 0, 8'hff, 0, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(4'b0001, 0, 0, 0, 8'hff, 0, 1, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 0, 8'hff, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 0, 8'hff, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 0, 8'hff, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 0, 8'hff, 2, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 0, 8'hff, 2, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 0, 8'h07, 3, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 0, 8'h07, 3, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'hff, 0, 1, 4'b0000, 0, 0, 0));

    i_rst_n = 1'b1;
    drive(0, 0, 0, 0, 8'hff, 0, 0);
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk_idle_outs("reset");
    chk("reset_timeout", 64'(tmo), 64'd0);
    nxt();
    i_rst_n = 1'b1;

    acc_cnt = 0;
    foreach (tbl[k]) begin
      v = tbl[k];
      drive(v.req, v.vld, v.last, v.user, v.keep, v.beat, v.trdy);
      @(negedge i_clk);
      chk($sformatf("v%0d_grant", k), 64'(grant), 64'(v.grant));
      chk($sformatf("v%0d_busy", k), 64'(busy), 64'(v.busy));
      chk($sformatf("v%0d_cur", k), 64'(cur), 64'(v.src));
      chk($sformatf("v%0d_tvalid", k), 64'(tx_vld),
          v.xfer ? 64'((v.vld >> v.src) & 4'd1) : 64'd0);
      chk($sformatf("v%0d_tdata", k), tx_data,
          v.xfer ? pat(int'(v.src), v.beat) : 64'd0);
      chk($sformatf("v%0d_tlast", k), 64'(tx_last),
          v.xfer ? 64'((v.last >> v.src) & 4'd1) : 64'd0);
      chk($sformatf("v%0d_tkeep", k), 64'(tx_keep),
          v.xfer ? 64'(v.keep) : 64'hff);
      chk($sformatf("v%0d_tuser", k), 64'(tx_user),
          v.xfer ? 64'((v.user >> v.src) & 4'd1) : 64'd0);
      chk($sformatf("v%0d_tready", k), 64'(rx_rdy),
          (v.xfer && v.trdy) ? 64'(4'd1 << v.src) : 64'd0);
      chk($sformatf("v%0d_timeout", k), 64'(tmo), 64'd0);
      if (tx_vld && tx_rdy) acc_cnt++;
      nxt();
    end
    chk("accepted_beats", 64'(acc_cnt), 64'd14);

    // all sources requesting: strict rotation with 2-cycle gaps
    drive(0, 0, 0, 0, 8'hff, 0, 1);
    i_rst_n = 1'b0;
    #1 i_rst_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      drive(4'b1111, 4'b1111, 0, 0, 8'hff, 0, 1);
      @(negedge i_clk);
      chk($sformatf("rr%0d_gap_grant", p), 64'(grant), 64'd0);
      chk($sformatf("rr%0d_gap_busy", p), 64'(busy), 64'd0);
      nxt();
      @(negedge i_clk);
      chk($sformatf("rr%0d_grant", p), 64'(grant),
          64'(4'd1 << (p % N)));
      nxt();
      @(negedge i_clk);
      chk($sformatf("rr%0d_pulse", p), 64'(grant), 64'd0);
      chk($sformatf("rr%0d_b0", p), tx_data, pat(p % N, 0));
      nxt();
      drive(4'b1111, 4'b1111, 4'b1111, 0, 8'hff, 1, 1);
      @(negedge i_clk);
      chk($sformatf("rr%0d_b1", p), tx_data, pat(p % N, 1));
      chk($sformatf("rr%0d_last", p), 64'(tx_last), 64'd1);
      chk($sformatf("rr%0d_cur", p), 64'(cur), 64'(p % N));
      nxt();
    end

    // reset during beat 3 of a packet from source 2
    drive(4'b0100, 4'b0100, 0, 0, 8'hff, 0, 1);
    nxt();
    @(negedge i_clk);
    chk("rst_grant", 64'(grant), 64'b0100);
    nxt();
    drive(0, 4'b0100, 0, 0, 8'hff, 0, 1);
    nxt();
    drive(0, 4'b0100, 0, 0, 8'hff, 1, 1);
    nxt();
    drive(0, 4'b0100, 0, 0, 8'hff, 2, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk_idle_outs("rst_async");
    drive(4'b1001, 0, 0, 0, 8'hff, 0, 1);
    nxt();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_idle_grant", 64'(grant), 64'd0);
    nxt();
    @(negedge i_clk);
    chk("rst_first_grant", 64'(grant), 64'b0001);
    nxt();
    drive(0, 4'b0001, 4'b0001, 0, 8'hff, 5, 1);
    @(negedge i_clk);
    chk("rst_pkt_data", tx_data, pat(0, 5));
    nxt();

    // stalled source 1
    drive(4'b0010, 0, 0, 0, 8'hff, 0, 1);
    @(negedge i_clk);
    chk("to_idle", 64'(busy), 64'd0);
    nxt();
    @(negedge i_clk);
    chk("to_grant", 64'(grant), 64'b0010);
    nxt();
    drive(0, 0, 0, 0, 8'hff, 0, 1);
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) drive(4'b0011, 0, 0, 0, 8'hff, 0, 1);
      @(negedge i_clk);
      chk($sformatf("to_cyc%0d", k), 64'(tmo), 64'(k == 16));
      nxt();
    end
    @(negedge i_clk);
    chk("to_after_busy", 64'(busy), 64'd0);
    chk("to_after_pulse", 64'(tmo), 64'd0);
    nxt();
    @(negedge i_clk);
    chk("to_next_grant", 64'(grant), 64'b0001);
    nxt();
    drive(0, 4'b0001, 4'b0001, 0, 8'hff, 0, 1);
    nxt();
`else
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (tmo) seen++;
      nxt();
    end
    chk("no_timeout", 64'(seen), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_cur", 64'(cur), 64'd1);
    i_rst_n = 1'b0;
    #1 i_rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
